// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID/EX pipeline register with load-use hazard detection, branch flush
//   and global hold. A load in EX whose destination feeds the instruction
//   in ID raises Stall_out (PC and IF/ID hold) and a bubble is loaded here.
//
// Ports
//   Clk_in, Rst_n_in            clock (rising edge), async active-low reset
//   Hold_in                     global freeze; all registers keep their value
//   Flush_in                    discard the instruction entering EX
//   IFIDValid_in, IFIDReg*_in   ID-stage valid bit and rs/rt/rd specifiers
//   UsesRt_in                   ID instruction reads rt as a source
//   ReadData1/2_in, Imm_in      operands and sign-extended immediate
//   RegWrite..ALUSrc_in, ALUOp_in  decoded control
//   IDEX*_out                   registered EX-stage copy of the above
//   Stall_out                   combinational load-use stall request
//   StallCount_out              load-use bubble count
//
// Build option
//   STALL_COUNTER_EN  when defined, StallCount_out is a saturating 32-bit
//                     count of load-use bubbles; otherwise it is tied to 0.

module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               Clk_in,
    input  logic               Rst_n_in,
    input  logic               Hold_in,
    input  logic               Flush_in,
    input  logic               IFIDValid_in,
    input  logic [4:0]         IFIDRegs_in,
    input  logic [4:0]         IFIDRegt_in,
    input  logic [4:0]         IFIDRegd_in,
    input  logic               UsesRt_in,
    input  logic [DATA_W-1:0]  ReadData1_in,
    input  logic [DATA_W-1:0]  ReadData2_in,
    input  logic [DATA_W-1:0]  Imm_in,
    input  logic               RegWrite_in,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               MemtoReg_in,
    input  logic               RegDst_in,
    input  logic               ALUSrc_in,
    input  logic [ALUOP_W-1:0] ALUOp_in,
    output logic               IDEXValid_out,
    output logic [4:0]         IDEXRegs_out,
    output logic [4:0]         IDEXRegt_out,
    output logic [4:0]         IDEXRegd_out,
    output logic [DATA_W-1:0]  IDEXReadData1_out,
    output logic [DATA_W-1:0]  IDEXReadData2_out,
    output logic [DATA_W-1:0]  IDEXImm_out,
    output logic               IDEXRegWrite_out,
    output logic               IDEXMemRead_out,
    output logic               IDEXMemWrite_out,
    output logic               IDEXMemtoReg_out,
    output logic               IDEXRegDst_out,
    output logic               IDEXALUSrc_out,
    output logic [ALUOP_W-1:0] IDEXALUOp_out,
    output logic               Stall_out,
    output logic [31:0]        StallCount_out
);

    logic               valid_q,    valid_d;
    logic [4:0]         rs_q,       rs_d;
    logic [4:0]         rt_q,       rt_d;
    logic [4:0]         rd_q,       rd_d;
    logic [DATA_W-1:0]  rdata1_q,   rdata1_d;
    logic [DATA_W-1:0]  rdata2_q,   rdata2_d;
    logic [DATA_W-1:0]  imm_q,      imm_d;
    logic               regwrite_q, regwrite_d;
    logic               memread_q,  memread_d;
    logic               memwrite_q, memwrite_d;
    logic               memtoreg_q, memtoreg_d;
    logic               regdst_q,   regdst_d;
    logic               alusrc_q,   alusrc_d;
    logic [ALUOP_W-1:0] aluop_q,    aluop_d;

    logic load_use;

    // Load in EX whose destination is a live source of the ID instruction.
    // rt only counts when the ID instruction actually reads it; $zero never
    // creates a dependency.
    always_comb begin
        load_use = valid_q & memread_q & (rt_q != 5'd0) & IFIDValid_in &
                   ((rt_q == IFIDRegs_in) | (UsesRt_in & (rt_q == IFIDRegt_in)));
    end

    // A flushed ID instruction is discarded upstream, so it must not stall.
    assign Stall_out = load_use & ~Flush_in;

    always_comb begin
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        imm_d      = imm_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        regdst_d   = regdst_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;

        if (Hold_in) begin
            // everything keeps its value
        end else if (Flush_in || load_use) begin
            // Bubble: data fields are left alone, they are don't-care once
            // the valid bit is low. Zeroed specifiers keep forwarding quiet.
            valid_d    = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            regdst_d   = 1'b0;
            alusrc_d   = 1'b0;
            aluop_d    = '0;
        end else begin
            // Invalid instructions load their fields, but their control bits
            // are masked so they can never write the register file or memory.
            valid_d    = IFIDValid_in;
            rs_d       = IFIDRegs_in;
            rt_d       = IFIDRegt_in;
            rd_d       = IFIDRegd_in;
            rdata1_d   = ReadData1_in;
            rdata2_d   = ReadData2_in;
            imm_d      = Imm_in;
            regwrite_d = RegWrite_in & IFIDValid_in;
            memread_d  = MemRead_in  & IFIDValid_in;
            memwrite_d = MemWrite_in & IFIDValid_in;
            memtoreg_d = MemtoReg_in & IFIDValid_in;
            regdst_d   = RegDst_in   & IFIDValid_in;
            alusrc_d   = ALUSrc_in   & IFIDValid_in;
            aluop_d    = ALUOp_in;
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            imm_q      <= imm_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            regdst_q   <= regdst_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts only bubbles actually inserted for load-use; saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use && !Flush_in && !Hold_in && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount_out = stall_cnt_q;
`else
    assign StallCount_out = '0;
`endif

    assign IDEXValid_out     = valid_q;
    assign IDEXRegs_out      = rs_q;
    assign IDEXRegt_out      = rt_q;
    assign IDEXRegd_out      = rd_q;
    assign IDEXReadData1_out = rdata1_q;
    assign IDEXReadData2_out = rdata2_q;
    assign IDEXImm_out       = imm_q;
    assign IDEXRegWrite_out  = regwrite_q;
    assign IDEXMemRead_out   = memread_q;
    assign IDEXMemWrite_out  = memwrite_q;
    assign IDEXMemtoReg_out  = memtoreg_q;
    assign IDEXRegDst_out    = regdst_q;
    assign IDEXALUSrc_out    = alusrc_q;
    assign IDEXALUOp_out     = aluop_q;

endmodule
